demux_rr_sched: RTL and testbench

Round-robin scheduler that sits in front of the 1-to-8 demultiplexer datapath and distributes a single valid/ready input stream across eight output lanes. It accepts beats, steers each one to the current lane, rotates to the next enabled lane after a fixed burst length, and holds each beat in a one-entry output register until the selected lane accepts it. Disabled lanes are skipped. No beat is ever dropped or duplicated.

---
 rtl/demux_rr_sched_if.sv | 19 +
 rtl/demux_rr_sched.sv | 51 +++++
 tb/tb_demux_rr_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/demux_rr_sched_if.sv
// demux_rr_sched_if: stream-in / eight-lane demux-out bundle for the round-robin scheduler
interface demux_rr_sched_if #(parameter int WIDTH = 8);
  logic [7:0]       lane_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       sel;
  modport master (
    output lane_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel
  );
  modport slave (
    input  lane_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin steering of one valid/ready stream onto eight lanes with a one-beat output register
module demux_rr_sched #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst,
  demux_rr_sched_if.slave bus
);
  logic             hold;
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       ptr;
  logic [3:0]       cnt;
  logic [2:0]       nxt;
  logic             fire;
  logic             acc;
  assign fire = hold && bus.out_ready[sel_q];
  assign bus.in_ready = bus.lane_en[ptr] && (!hold || bus.out_ready[sel_q]);
  assign acc = bus.in_valid && bus.in_ready;
  assign bus.out_valid = hold ? 8'b1 << sel_q : 8'h00;
  assign bus.out_data = data_q;
  assign bus.sel = sel_q;
  // next enabled lane after ptr; scanning downward lets the nearest candidate win, ptr itself if none
  always_comb begin
    nxt = ptr;
    for (int i = 7; i >= 1; i--) if (bus.lane_en[ptr + 3'(i)]) nxt = ptr + 3'(i);
  end
  // output register, burst counter and lane pointer; realign only when no accept is possible
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else if (acc) begin
      hold   <= 1'b1;
      sel_q  <= ptr;
      data_q <= bus.in_data;
      cnt    <= (cnt == 4'(BURST - 1)) ? 4'd0 : cnt + 4'd1;
      ptr    <= (cnt == 4'(BURST - 1)) ? nxt : ptr;
    end else begin
      if (fire) hold <= 1'b0;
      if (!bus.lane_en[ptr] && |bus.lane_en) begin
        ptr <= nxt;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: directed vectors for the round-robin lane scheduler
module tb_demux_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int lanes1 [8] = '{0, 2, 5, 7, 0, 2, 5, 7};
  demux_rr_sched_if #(.WIDTH(8)) b4();
  demux_rr_sched_if #(.WIDTH(8)) b1();
  demux_rr_sched #(.WIDTH(8), .BURST(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  demux_rr_sched #(.WIDTH(8), .BURST(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    b4.lane_en = 8'hFF; b4.in_valid = 0; b4.in_data = 0; b4.out_ready = 8'h00;
    b1.lane_en = 8'h00; b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 8'h00;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_valid", 32'(b4.out_valid), 0);
    chk("rst_sel", 32'(b4.sel), 0);
    chk("rst_data", 32'(b4.out_data), 0);
    chk("rst_ready", 32'(b4.in_ready), 1);
    b4.in_valid = 1; b4.out_ready = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      b4.in_data = 8'(i);
      #1 chk("stream_rdy", 32'(b4.in_ready), 1);
      tick();
      chk("stream_sel", 32'(b4.sel), 32'(i / 4));
      chk("stream_ov", 32'(b4.out_valid), 32'(8'b1 << (i / 4)));
      chk("stream_data", 32'(b4.out_data), 32'(i));
    end
    b4.in_data = 8'h40;
    tick();
    chk("bp_first_sel", 32'(b4.sel), 0);
    b4.in_data = 8'h41; b4.out_ready = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_rdy", 32'(b4.in_ready), 0);
      tick();
      chk("bp_ov", 32'(b4.out_valid), 32'h01);
      chk("bp_data", 32'(b4.out_data), 32'h40);
    end
    b4.out_ready = 8'hFF;
    #1 chk("bp_rel_rdy", 32'(b4.in_ready), 1);
    tick();
    chk("bp_rel_data", 32'(b4.out_data), 32'h41);
    for (int i = 2; i < 6; i++) begin
      b4.in_data = 8'(8'h40 + i);
      #1 chk("resume_rdy", 32'(b4.in_ready), 1);
      tick();
      chk("resume_sel", 32'(b4.sel), i < 4 ? 0 : 1);
    end
    b4.out_ready = 8'h00; b4.lane_en = 8'hFD; b4.in_data = 8'h46;
    #1 chk("dis_rdy", 32'(b4.in_ready), 0);
    tick();
    chk("dis_ov", 32'(b4.out_valid), 32'h02);
    chk("dis_data", 32'(b4.out_data), 32'h45);
    b4.out_ready = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      b4.in_data = 8'(8'h46 + i);
      #1 chk("realign_rdy", 32'(b4.in_ready), 1);
      tick();
      chk("realign_sel", 32'(b4.sel), i < 4 ? 2 : 3);
    end
    b4.lane_en = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1 chk("off_rdy", 32'(b4.in_ready), 0);
      tick();
      chk("off_ov", 32'(b4.out_valid), 0);
    end
    b4.lane_en = 8'h08;
    for (int i = 0; i < 8; i++) begin
      b4.in_data = 8'(8'h50 + i);
      #1 chk("l3_rdy", 32'(b4.in_ready), 1);
      tick();
      chk("l3_sel", 32'(b4.sel), 3);
      chk("l3_data", 32'(b4.out_data), 32'(8'h50 + i));
    end
    b4.in_valid = 0; b4.lane_en = 8'h40;
    tick();
    chk("l6_drain", 32'(b4.out_valid), 0);
    b4.in_valid = 1; b4.in_data = 8'h60; b4.out_ready = 8'h00;
    #1 chk("l6_rdy", 32'(b4.in_ready), 1);
    tick();
    chk("l6_ov", 32'(b4.out_valid), 32'h40);
    chk("l6_sel", 32'(b4.sel), 6);
    b4.in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst2_ov", 32'(b4.out_valid), 0);
    chk("rst2_sel", 32'(b4.sel), 0);
    b4.lane_en = 8'hFF; b4.out_ready = 8'hFF; b4.in_valid = 1; b4.in_data = 8'h70;
    tick();
    chk("rst2_first_sel", 32'(b4.sel), 0);
    chk("rst2_first_data", 32'(b4.out_data), 32'h70);
    b4.in_valid = 0;
    b1.lane_en = 8'b1010_0101; b1.out_ready = 8'hFF; b1.in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      b1.in_data = 8'(8'h80 + i);
      #1 chk("b1_rdy", 32'(b1.in_ready), 1);
      tick();
      chk("b1_sel", 32'(b1.sel), 32'(lanes1[i]));
      chk("b1_data", 32'(b1.out_data), 32'(8'h80 + i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
